// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-lite datapath.
// Build option MC_ILLEGAL_HALT_EN: unsupported instructions halt instead of acting as NOPs.
module mc_ctrl #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ext_sign,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  rf_dst_sel,
  output logic [1:0]  rf_wd_sel,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  logic [5:0] op, funct;
  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_legal, is_memop;
  logic       alu_src_i;
  logic [2:0] alu_op_i;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  assign is_addu  = (op == 6'h00) && (funct == 6'h21);
  assign is_subu  = (op == 6'h00) && (funct == 6'h23);
  assign is_jr    = (op == 6'h00) && (funct == 6'h08);
  assign is_ori   = (op == 6'h0D);
  assign is_lui   = (op == 6'h0F);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);
  assign is_memop = is_lw | is_sw;
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui | is_memop |
                    is_beq | is_j | is_jal;

  // ALU setup shared by EXEC and WB so the datapath result stays stable through writeback.
  assign alu_src_i = is_ori | is_lui | is_memop;
  assign alu_op_i  = (is_subu | is_beq) ? 3'd1 :
                     is_ori             ? 3'd2 :
                     is_lui             ? 3'd3 : 3'd0;

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths that skip an
    // assignment would infer latches.
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    ext_sign   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'd0;
    rf_we      = 1'b0;
    rf_dst_sel = 2'd0;
    rf_wd_sel  = 2'd0;
    halted     = 1'b0;
    state_d    = state_q;
    err_d      = err_q;
    wait_d     = 8'd0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        ext_sign = is_memop | is_beq;
        if (is_j || is_jal) begin
          pc_we   = 1'b1;
          pc_sel  = 2'd2;
          state_d = S_FETCH;
          if (is_jal) begin
            rf_we      = 1'b1;
            rf_dst_sel = 2'd2;
            rf_wd_sel  = 2'd2;
          end
        end else if (is_jr) begin
          pc_we   = 1'b1;
          pc_sel  = 2'd3;
          state_d = S_FETCH;
        end else if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        ext_sign = is_memop | is_beq;
        alu_src  = alu_src_i;
        alu_op   = alu_op_i;
        if (is_beq) begin
          pc_we   = zero;
          pc_sel  = 2'd1;
          state_d = S_FETCH;
        end else if (is_memop) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ext_sign = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        alu_src  = 1'b1;
        alu_op   = 3'd0;
        if (dmem_ready) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        ext_sign   = is_memop | is_beq;
        alu_src    = alu_src_i;
        alu_op     = alu_op_i;
        rf_we      = 1'b1;
        rf_dst_sel = (is_addu | is_subu) ? 2'd1 : 2'd0;
        rf_wd_sel  = is_lw ? 2'd1 : 2'd0;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench; an instruction-level model expands each
// instruction into expected per-cycle outputs that a negedge monitor compares.
module tb_mc_ctrl;

  localparam int unsigned WMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic        ext_sign, alu_src;
  logic [2:0]  alu_op;
  logic        rf_we;
  logic [1:0]  rf_dst_sel, rf_wd_sel;
  logic        halted, err;

  mc_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .ext_sign(ext_sign),
    .alu_src(alu_src), .alu_op(alu_op), .rf_we(rf_we),
    .rf_dst_sel(rf_dst_sel), .rf_wd_sel(rf_wd_sel),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ext_sign;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       rf_we;
    logic [1:0] rf_dst_sel;
    logic [1:0] rf_wd_sel;
    logic       halted;
    logic       err;
  } outs_t;

  typedef struct packed {
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic [31:0] instr;
    outs_t       exp;
  } cyc_t;

  typedef enum int {
    C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_e;

  outs_t act;
  assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, ext_sign, alu_src,
                alu_op, rf_we, rf_dst_sel, rf_wd_sel, halted, err};

  cyc_t  prog_q[$];
  outs_t exp_q[$];
  outs_t mon_e;
  int    total = 0;
  int    bad = 0;
  int    ncyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents each cycle against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        ncyc++;
        check($sformatf("cycle%0d_outs", ncyc), 64'(act), 64'(mon_e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  function automatic bit supported(input logic [31:0] w);
    logic [5:0] o;
    logic [5:0] f;
    o = w[31:26];
    f = w[5:0];
    if (o == 6'h00) return (f == 6'h21) || (f == 6'h23) || (f == 6'h08);
    return o inside {6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  endfunction

  function automatic logic [31:0] enc(input cls_e c);
    logic [31:0] r;
    r = $urandom;
    case (c)
      C_ADDU: return {6'h00, r[25:6], 6'h21};
      C_SUBU: return {6'h00, r[25:6], 6'h23};
      C_JR:   return {6'h00, r[25:6], 6'h08};
      C_ORI:  return {6'h0D, r[25:0]};
      C_LUI:  return {6'h0F, r[25:0]};
      C_LW:   return {6'h23, r[25:0]};
      C_SW:   return {6'h2B, r[25:0]};
      C_BEQ:  return {6'h04, r[25:0]};
      C_J:    return {6'h02, r[25:0]};
      C_JAL:  return {6'h03, r[25:0]};
      default: begin
        while (supported(r)) r = $urandom;
        return r;
      end
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input cls_e c);
    case (c)
      C_SUBU, C_BEQ: return 3'd1;
      C_ORI:         return 3'd2;
      C_LUI:         return 3'd3;
      default:       return 3'd0;
    endcase
  endfunction

  task automatic add_cyc(input logic ir, input logic dr, input logic z,
                         input logic [31:0] iw, input outs_t o);
    cyc_t c;
    c.imem_ready = ir;
    c.dmem_ready = dr;
    c.zero       = z;
    c.instr      = iw;
    c.exp        = o;
    prog_q.push_back(c);
  endtask

  task automatic add_halt(input logic e);
    outs_t o;
    for (int i = 0; i < 3; i++) begin
      o = '0;
      o.halted = 1'b1;
      o.err    = e;
      add_cyc(rb(), rb(), rb(), $urandom, o);
    end
  endtask

  // Reference model: expands one instruction into its cycle-by-cycle contract.
  task automatic gen_instr(input cls_e c, input logic [31:0] iw, input int fw,
                           input int mw, input logic z, output bit halts);
    outs_t o;
    logic  es;
    halts = 0;
    es = (c == C_LW) || (c == C_SW) || (c == C_BEQ);
    for (int i = 0; i < fw && i < int'(WMAX); i++) begin
      o = '0;
      o.imem_req = 1'b1;
      add_cyc(1'b0, rb(), rb(), $urandom, o);
    end
    if (fw >= int'(WMAX)) begin
      add_halt(1'b1);
      halts = 1;
      return;
    end
    o = '0;
    o.imem_req = 1'b1;
    o.ir_we    = 1'b1;
    o.pc_we    = 1'b1;
    add_cyc(1'b1, rb(), rb(), $urandom, o);

    o = '0;
    o.ext_sign = es;
    if (c == C_J || c == C_JAL) begin
      o.pc_we  = 1'b1;
      o.pc_sel = 2'd2;
    end
    if (c == C_JAL) begin
      o.rf_we      = 1'b1;
      o.rf_dst_sel = 2'd2;
      o.rf_wd_sel  = 2'd2;
    end
    if (c == C_JR) begin
      o.pc_we  = 1'b1;
      o.pc_sel = 2'd3;
    end
    add_cyc(rb(), rb(), rb(), iw, o);
    if (c == C_J || c == C_JAL || c == C_JR) return;
    if (c == C_ILL) begin
`ifdef MC_ILLEGAL_HALT_EN
      add_halt(1'b0);
      halts = 1;
`endif
      return;
    end

    o = '0;
    o.ext_sign = es;
    o.alu_src  = (c == C_ORI) || (c == C_LUI) || (c == C_LW) || (c == C_SW);
    o.alu_op   = alu_of(c);
    if (c == C_BEQ) begin
      o.pc_we  = z;
      o.pc_sel = 2'd1;
    end
    add_cyc(rb(), rb(), z, iw, o);
    if (c == C_BEQ) return;

    if (c == C_LW || c == C_SW) begin
      o = '0;
      o.ext_sign = 1'b1;
      o.dmem_req = 1'b1;
      o.dmem_we  = (c == C_SW);
      o.alu_src  = 1'b1;
      for (int i = 0; i < mw && i < int'(WMAX); i++) add_cyc(rb(), 1'b0, rb(), iw, o);
      if (mw >= int'(WMAX)) begin
        add_halt(1'b1);
        halts = 1;
        return;
      end
      add_cyc(rb(), 1'b1, rb(), iw, o);
      if (c == C_SW) return;
    end

    o = '0;
    o.ext_sign   = es;
    o.alu_src    = (c == C_ORI) || (c == C_LUI) || (c == C_LW);
    o.alu_op     = alu_of(c);
    o.rf_we      = 1'b1;
    o.rf_dst_sel = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
    o.rf_wd_sel  = (c == C_LW) ? 2'd1 : 2'd0;
    add_cyc(rb(), rb(), rb(), iw, o);
  endtask

  // Driver: applies each cycle's inputs right after the edge and hands the expectation over.
  task automatic play(input int n);
    cyc_t c;
    for (int k = 0; k < n && prog_q.size() > 0; k++) begin
      c = prog_q.pop_front();
      imem_ready = c.imem_ready;
      dmem_ready = c.dmem_ready;
      zero       = c.zero;
      instr      = c.instr;
      exp_q.push_back(c.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    outs_t r;
    r = '0;
    r.imem_req = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check({tag, "_reset_outs"}, 64'(act), 64'(r));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_one(input cls_e c, input logic [31:0] iw, input int fw,
                         input int mw, input logic z, input string tag);
    bit h;
    gen_instr(c, iw, fw, mw, z, h);
    play(prog_q.size());
    if (h) do_reset(tag);
  endtask

  task automatic run_all();
    outs_t r;
    bit    h;
    cls_e  c;
    int    fw;
    int    mw;

    do_reset("init");

    run_one(C_ADDU, 32'h0022_1821, 0, 0, 1'b0, "addu");
    run_one(C_LW,   32'h8FA8_FFFC, 0, 3, 1'b0, "lw");
    run_one(C_BEQ,  32'h1022_0003, 0, 0, 1'b1, "beq_taken");
    run_one(C_BEQ,  32'h1022_0003, 0, 0, 1'b0, "beq_not");
    run_one(C_JAL,  32'h0C10_0004, 0, 0, 1'b0, "jal");
    run_one(C_ADDU, 32'h0022_1821, int'(WMAX), 0, 1'b0, "fetch_to");
    run_one(C_ADDU, 32'h0022_1821, int'(WMAX) - 1, 0, 1'b0, "fetch_edge");
    run_one(C_SW,   enc(C_SW), 1, int'(WMAX), 1'b0, "mem_to");
    run_one(C_LW,   enc(C_LW), 0, int'(WMAX) - 1, 1'b0, "mem_edge");
    run_one(C_ILL,  32'hFC00_0000, 0, 0, 1'b0, "op3f");
    run_one(C_J,    enc(C_J), 0, 0, 1'b0, "j");

    // Asynchronous reset while a store is waiting in MEM.
    gen_instr(C_SW, enc(C_SW), 0, 3, 1'b0, h);
    play(5);
    prog_q.delete();
    dmem_ready = 1'b0;
    imem_ready = 1'b0;
    #1;
    check("sw_mem_req_before_rst", 64'({dmem_req, dmem_we}), 64'(2'b11));
    #2;
    reset = 1'b0;
    #1;
    r = '0;
    r.imem_req = 1'b1;
    check("sw_mem_async_rst", 64'(act), 64'(r));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_one(C_ADDU, enc(C_ADDU), 0, 0, 1'b0, "after_rst");

    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(19, 0) == 0) ? C_ILL : cls_e'($urandom_range(9, 0));
      fw = ($urandom_range(39, 0) == 0) ? int'(WMAX) : int'($urandom_range(3, 0));
      mw = ($urandom_range(19, 0) == 0) ? int'(WMAX) : int'($urandom_range(3, 0));
      run_one(c, enc(c), fw, mw, rb(), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    run_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
